// File: rtl/bist_sig_analyzer.sv
// MISR signature compactor with BIST sequencing: reseeds the upstream pattern
// LFSR, compacts a programmed number of products, and compares against golden.
module bist_sig_analyzer #(
   parameter int unsigned N     = 64,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [N-1:0]     poly,
   input  logic [N-1:0]     golden,
   input  logic [N-1:0]     din,
   input  logic             din_valid,
   output logic             lfsr_rst,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N-1:0]     signature,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEED,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [N-1:0]     poly_q;
   logic [N-1:0]     golden_q;
   logic [N-1:0]     sig_q;
   logic [N-1:0]     sig_d;
   logic [CNT_W-1:0] rem_q;
   logic             lfsr_rst_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;

   always_comb begin
      sig_d = {sig_q[N-2:0], ^(poly_q & sig_q)} ^ din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         poly_q     <= '0;
         golden_q   <= '0;
         sig_q      <= '0;
         rem_q      <= '0;
         lfsr_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else if (abort) begin
         // signature and remaining are deliberately kept for post-abort debug
         state_q    <= S_IDLE;
         lfsr_rst_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_SEED;
                  poly_q     <= poly;
                  golden_q   <= golden;
                  rem_q      <= num_patterns;
                  sig_q      <= '0;
                  lfsr_rst_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            S_SEED: begin
               lfsr_rst_q <= 1'b0;
               if (rem_q == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (sig_q == golden_q);
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (din_valid) begin
                  sig_q <= sig_d;
                  rem_q <= rem_q - CNT_W'(1);
                  // pass uses the post-update signature so it is valid with done
                  if (rem_q == CNT_W'(1)) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (sig_d == golden_q);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign lfsr_rst  = lfsr_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign remaining = rem_q;

endmodule

// File: tb/tb_bist_sig_analyzer.sv
// Directed bench for bist_sig_analyzer (N=8) with a scoreboard of expected
// end-of-run signature/pass results.
module tb_bist_sig_analyzer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] num_patterns;
   logic [7:0] poly;
   logic [7:0] golden;
   logic [7:0] din;
   logic       din_valid;
   logic       lfsr_rst;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] signature;
   logic [7:0] remaining;

   bist_sig_analyzer #(.N(8), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .num_patterns (num_patterns),
      .poly         (poly),
      .golden       (golden),
      .din          (din),
      .din_valid    (din_valid),
      .lfsr_rst     (lfsr_rst),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .signature    (signature),
      .remaining    (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sig;
      logic       pass;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] m_sig;
   logic [7:0] m_poly;
   logic [7:0] m_gold;
   logic [7:0] m_rem;
   logic [7:0] saved_sig;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] num, input logic [7:0] p, input logic [7:0] g);
      start        = 1'b1;
      num_patterns = num;
      poly         = p;
      golden       = g;
      tick();
      start  = 1'b0;
      m_sig  = 8'h00;
      m_poly = p;
      m_gold = g;
      m_rem  = num;
      if (num == 8'd0) sb.push_back('{8'h00, (g == 8'h00)});
      check("seed_lfsr_rst", lfsr_rst, 1);
      check("seed_busy", busy, 1);
      check("seed_done", done, 0);
      check("seed_sig_clear", signature, 8'h00);
      check("seed_remaining", remaining, num);
      tick();
      check("lfsr_rst_one_cycle", lfsr_rst, 0);
   endtask

   task automatic feed(input logic [7:0] d);
      din       = d;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      m_sig = {m_sig[6:0], ^(m_poly & m_sig)} ^ d;
      m_rem = m_rem - 8'd1;
      if (m_rem == 8'd0) sb.push_back('{m_sig, (m_sig == m_gold)});
      check("feed_sig", signature, m_sig);
      check("feed_remaining", remaining, m_rem);
   endtask

   task automatic score_run();
      exp_t e;
      for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
      check("done_reached", done, 1);
      check("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_signature", signature, e.sig);
         check("sb_pass", pass, e.pass);
      end
      check("done_busy", busy, 0);
      check("done_remaining", remaining, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b1; abort = 1'b0; din_valid = 1'b1;
      num_patterns = 8'd5; poly = 8'hB8; golden = 8'h00; din = 8'hFF;
      tick();
      tick();
      check("rst_lfsr_rst", lfsr_rst, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_signature", signature, 8'h00);
      check("rst_remaining", remaining, 8'h00);
      rst = 1'b0; start = 1'b0; din_valid = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      // single sample
      do_start(8'd1, 8'hB8, 8'h5A);
      check("run_busy", busy, 1);
      feed(8'h5A);
      check("single_sig_const", signature, 8'h5A);
      check("single_done_next", done, 1);
      check("single_pass_const", pass, 1);
      score_run();

      // feedback and shift with bubbles, started from DONE
      do_start(8'd3, 8'hB8, 8'h03);
      feed(8'h80);
      check("fb_sig1_const", signature, 8'h80);
      din = 8'h7F; tick();
      check("bubble_sig", signature, 8'h80);
      check("bubble_rem", remaining, 8'd2);
      feed(8'h00);
      check("fb_sig2_const", signature, 8'h01);
      tick();
      check("bubble2_sig", signature, 8'h01);
      feed(8'h02);
      check("fb_sig3_const", signature, 8'h00);
      check("fb_pass_const", pass, 0);
      score_run();

      // din_valid ignored in DONE
      saved_sig = signature;
      din = 8'hFF; din_valid = 1'b1; tick(); din_valid = 1'b0;
      check("done_ignores_din", signature, saved_sig);
      check("done_held", done, 1);

      // zero patterns
      do_start(8'd0, 8'hB8, 8'h00);
      check("zero_done", done, 1);
      score_run();
      do_start(8'd0, 8'hB8, 8'h01);
      check("zero_pass_const", pass, 0);
      score_run();

      // abort mid-run
      do_start(8'd10, 8'hB8, 8'h00);
      feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
      abort = 1'b1; din = 8'h55; din_valid = 1'b1; tick();
      abort = 1'b0; din_valid = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_remaining", remaining, 8'd6);
      check("abort_sig_kept", signature, m_sig);
      din = 8'hA5; din_valid = 1'b1; tick(); din_valid = 1'b0;
      check("idle_ignores_din", signature, m_sig);
      check("idle_remaining", remaining, 8'd6);

      // fresh run after abort, with start pulses ignored during RUN
      do_start(8'd3, 8'h8E, 8'h00);
      start = 1'b1; num_patterns = 8'd9;
      feed(8'hC3);
      check("start_in_run_lfsr", lfsr_rst, 0);
      check("start_in_run_busy", busy, 1);
      feed(8'h3C);
      start = 1'b0;
      feed(8'h99);
      score_run();

      // restart from DONE with new golden matching the model result
      do_start(8'd2, 8'h1D, 8'h00);
      check("restart_done_low", done, 0);
      feed(8'h12);
      feed(8'h34);
      score_run();
      saved_sig = m_sig;
      do_start(8'd2, 8'h1D, saved_sig);
      feed(8'h12);
      feed(8'h34);
      score_run();
      check("restart_pass_repeat", pass, 1);

      // abort has priority over start in DONE
      abort = 1'b1; start = 1'b1; tick();
      abort = 1'b0; start = 1'b0;
      check("abort_over_start_lfsr", lfsr_rst, 0);
      check("abort_over_start_busy", busy, 0);
      check("abort_over_start_done", done, 0);
      check("abort_over_start_pass", pass, 0);

      // reset mid-run
      do_start(8'd5, 8'hB8, 8'h00);
      feed(8'h0F); feed(8'hF0);
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_sig", signature, 8'h00);
      check("midrst_rem", remaining, 8'h00);
      check("midrst_busy", busy, 0);
      tick();
      check("midrst_idle", busy, 0);

      check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
